// File: rtl/mem_master.sv
// Single-port memory master: turns CPU load/store requests into word-wide memory cycles.
// Define MEM_MASTER_RMW_EN to support byte stores via a read-modify-write; otherwise they are rejected.
module mem_master (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err,
    output logic [15:0] addrm,
    output logic [15:0] wmdata,
    output logic        re,
    output logic        we,
    output logic        mem_alu,
    input  logic [15:0] rmdata
);

`ifdef MEM_MASTER_RMW_EN
    typedef enum logic [2:0] {IDLE, ACCESS, RMW_RD, RMW_WR, RESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
`endif

    state_t      state;
    logic [15:0] addr_q;
    logic        we_q;
    logic        byte_q;
    logic [15:0] wdata_q;

    assign req_ready = (state == IDLE);
    assign mem_alu   = 1'b0;

`ifdef MEM_MASTER_RMW_EN
    logic [15:0] merge_q;
    logic [15:0] merged;

    // The store byte overlays the lane selected by the low address bit of the word read back.
    assign merged = addr_q[0] ? {wdata_q[7:0], merge_q[7:0]} : {merge_q[15:8], wdata_q[7:0]};
    assign wmdata = (state == RMW_WR) ? merged : wdata_q;
`else
    assign wmdata = wdata_q;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            addr_q    <= 16'h0000;
            we_q      <= 1'b0;
            byte_q    <= 1'b0;
            wdata_q   <= 16'h0000;
            addrm     <= 16'h0000;
            re        <= 1'b0;
            we        <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 16'h0000;
`ifdef MEM_MASTER_RMW_EN
            merge_q   <= 16'h0000;
`endif
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        addr_q  <= req_addr;
                        we_q    <= req_we;
                        byte_q  <= req_byte;
                        wdata_q <= req_wdata;
                        addrm   <= {req_addr[15:1], 1'b0};
                        if (!req_byte && req_addr[0]) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
                        end else if (req_we && req_byte) begin
`ifdef MEM_MASTER_RMW_EN
                            state <= RMW_RD;
                            re    <= 1'b1;
`else
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_err   <= 1'b1;
`endif
                        end else begin
                            state <= ACCESS;
                            re    <= !req_we;
                            we    <= req_we;
                        end
                    end
                end
                ACCESS: begin
                    re <= 1'b0;
                    we <= 1'b0;
                    if (!we_q) begin
                        rsp_rdata <= byte_q ? {8'h00, (addr_q[0] ? rmdata[15:8] : rmdata[7:0])} : rmdata;
                    end
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
`ifdef MEM_MASTER_RMW_EN
                RMW_RD: begin
                    re      <= 1'b0;
                    we      <= 1'b1;
                    merge_q <= rmdata;
                    state   <= RMW_WR;
                end
                RMW_WR: begin
                    we        <= 1'b0;
                    rsp_err   <= 1'b0;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
`endif
                RESP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_master.sv
// Randomised and directed bench for mem_master against a word-array reference model.
module tb_mem_master;

`ifdef MEM_MASTER_RMW_EN
    localparam bit RMW = 1'b1;
`else
    localparam bit RMW = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic        req_byte;
    logic [15:0] req_addr;
    logic [15:0] req_wdata;
    logic        rsp_valid;
    logic [15:0] rsp_rdata;
    logic        rsp_err;
    logic [15:0] addrm;
    logic [15:0] wmdata;
    logic        re;
    logic        we;
    logic        mem_alu;
    logic [15:0] rmdata;

    int checks = 0;
    int fails  = 0;

    logic [15:0] mem     [0:32767];
    logic [15:0] ref_mem [0:32767];
    logic [15:0] ref_rdata;

    always #5 clock = ~clock;

    mem_master dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_byte  (req_byte),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .addrm     (addrm),
        .wmdata    (wmdata),
        .re        (re),
        .we        (we),
        .mem_alu   (mem_alu),
        .rmdata    (rmdata)
    );

    // Behavioural memory: combinational read, write commits at the edge ending the we cycle.
    assign rmdata = mem[addrm[15:1]];
    always @(posedge clock) begin
        if (we) mem[addrm[15:1]] <= wmdata;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n === 1'b1) begin
            checkOutput("re_we_exclusive", {31'b0, re & we}, 32'h0);
            checkOutput("mem_alu_zero", {31'b0, mem_alu}, 32'h0);
            checkOutput("addrm_even", {31'b0, addrm[0]}, 32'h0);
        end
    end

    // Issues one request and observes it until its response pulse (bounded).
    task automatic applyStimulus(input bit wr, input bit bt, input logic [15:0] addr, input logic [15:0] wdata,
                                 output int latency, output bit saw_re, output bit saw_we,
                                 output logic [15:0] mem_addr);
        latency  = 0;
        saw_re   = 1'b0;
        saw_we   = 1'b0;
        mem_addr = 16'h0000;
        @(negedge clock);
        req_valid = 1'b1;
        req_we    = wr;
        req_byte  = bt;
        req_addr  = addr;
        req_wdata = wdata;
        checkOutput("req_ready_idle", {31'b0, req_ready}, 32'h1);
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        req_wdata = $urandom;
        for (int c = 1; c <= 10; c++) begin
            @(negedge clock);
            if (re) begin saw_re = 1'b1; mem_addr = addrm; end
            if (we) begin saw_we = 1'b1; mem_addr = addrm; end
            if (rsp_valid) begin
                latency = c;
                checkOutput("req_ready_in_resp", {31'b0, req_ready}, 32'h0);
                break;
            end
        end
        @(negedge clock);
        checkOutput("rsp_valid_one_cycle", {31'b0, rsp_valid}, 32'h0);
    endtask

    // Predicts a request's outcome from the memory-level rules, then checks the DUT.
    task automatic doTransaction(input bit wr, input bit bt, input logic [15:0] addr, input logic [15:0] wdata);
        int          lat;
        bit          s_re;
        bit          s_we;
        logic [15:0] m_addr;
        bit          err;
        int          exp_lat;
        int          idx;
        logic [15:0] word;
        idx  = int'(addr[15:1]);
        word = ref_mem[idx];
        err  = (!bt && addr[0]) || (wr && bt && !RMW);
        exp_lat = err ? 1 : ((wr && bt) ? 3 : 2);
        if (!err && !wr) ref_rdata = bt ? {8'h00, (addr[0] ? word[15:8] : word[7:0])} : word;
        if (!err && wr) begin
            if (!bt) ref_mem[idx] = wdata;
            else if (addr[0]) ref_mem[idx] = {wdata[7:0], word[7:0]};
            else ref_mem[idx] = {word[15:8], wdata[7:0]};
        end
        applyStimulus(wr, bt, addr, wdata, lat, s_re, s_we, m_addr);
        checkOutput("latency", lat, exp_lat);
        checkOutput("rsp_err", {31'b0, rsp_err}, {31'b0, err});
        checkOutput("rsp_rdata", {16'h0, rsp_rdata}, {16'h0, ref_rdata});
        checkOutput("saw_re", {31'b0, s_re}, {31'b0, !err && (!wr || bt)});
        checkOutput("saw_we", {31'b0, s_we}, {31'b0, !err && wr});
        if (!err) checkOutput("addrm", {16'h0, m_addr}, {16'h0, addr & 16'hFFFE});
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit          wr;
        bit          bt;
        logic [15:0] a;
        bit          saw_rsp;

        for (int i = 0; i < 32768; i++) begin
            mem[i]     = 16'h0000;
            ref_mem[i] = 16'h0000;
        end
        ref_rdata = 16'h0000;
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_byte  = 1'b0;
        req_addr  = 16'h0000;
        req_wdata = 16'h0000;
        #1;
        checkOutput("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        checkOutput("reset_rsp_err", {31'b0, rsp_err}, 32'h0);
        checkOutput("reset_rsp_rdata", {16'h0, rsp_rdata}, 32'h0);
        checkOutput("reset_addrm", {16'h0, addrm}, 32'h0);
        checkOutput("reset_wmdata", {16'h0, wmdata}, 32'h0);
        checkOutput("reset_re", {31'b0, re}, 32'h0);
        checkOutput("reset_we", {31'b0, we}, 32'h0);
        checkOutput("reset_mem_alu", {31'b0, mem_alu}, 32'h0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        #1;
        checkOutput("ready_after_reset", {31'b0, req_ready}, 32'h1);

        $display("[TB] directed: word store / word load");
        doTransaction(1'b1, 1'b0, 16'h0010, 16'hBEEF);
        doTransaction(1'b0, 1'b0, 16'h0010, 16'h0000);
        checkOutput("word_load_beef", {16'h0, rsp_rdata}, 32'h0000BEEF);

        $display("[TB] directed: byte load high lane");
        doTransaction(1'b0, 1'b1, 16'h0011, 16'h0000);
        checkOutput("byte_load_be", {16'h0, rsp_rdata}, 32'h000000BE);

        $display("[TB] directed: byte store then word load");
        doTransaction(1'b1, 1'b1, 16'h0011, 16'h0042);
        checkOutput("byte_store_err", {31'b0, rsp_err}, {31'b0, !RMW});
        doTransaction(1'b0, 1'b0, 16'h0010, 16'h0000);
        checkOutput("after_byte_store", {16'h0, rsp_rdata}, RMW ? 32'h000042EF : 32'h0000BEEF);

        $display("[TB] directed: misaligned word load");
        doTransaction(1'b0, 1'b0, 16'h0013, 16'h0000);
        checkOutput("misaligned_err", {31'b0, rsp_err}, 32'h1);

        $display("[TB] directed: reset during write cycle");
        doTransaction(1'b1, 1'b0, 16'h0020, 16'h1111);
        @(negedge clock);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_byte  = 1'b0;
        req_addr  = 16'h0020;
        req_wdata = 16'h2222;
        @(posedge clock);
        #1;
        req_valid = 1'b0;
        @(negedge clock);
        checkOutput("we_before_reset", {31'b0, we}, 32'h1);
        reset_n = 1'b0;
        #1;
        checkOutput("rst_we_dropped", {31'b0, we}, 32'h0);
        checkOutput("rst_re", {31'b0, re}, 32'h0);
        checkOutput("rst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        checkOutput("rst_rsp_err", {31'b0, rsp_err}, 32'h0);
        checkOutput("rst_rsp_rdata", {16'h0, rsp_rdata}, 32'h0);
        checkOutput("rst_addrm", {16'h0, addrm}, 32'h0);
        checkOutput("rst_wmdata", {16'h0, wmdata}, 32'h0);
        @(negedge clock);
        checkOutput("mem_not_written", {16'h0, mem[16'h0010]}, 32'h00001111);
        ref_rdata = 16'h0000;
        reset_n   = 1'b1;
        saw_rsp   = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clock);
            if (rsp_valid) saw_rsp = 1'b1;
        end
        checkOutput("no_rsp_after_reset", {31'b0, saw_rsp}, 32'h0);
        checkOutput("ready_after_reset2", {31'b0, req_ready}, 32'h1);
        doTransaction(1'b0, 1'b0, 16'h0020, 16'h0000);
        checkOutput("reload_1111", {16'h0, rsp_rdata}, 32'h00001111);

        $display("[TB] random traffic");
        for (int n = 0; n < 250; n++) begin
            wr = 1'(($urandom & 32'h1));
            bt = 1'(($urandom & 32'h1));
            if ($urandom_range(0, 7) == 0) a = 16'hFFFE | 16'($urandom_range(0, 1));
            else a = 16'h0040 + 16'($urandom_range(0, 31));
            doTransaction(wr, bt, a, 16'($urandom));
        end

        for (int i = 16'h0020; i < 16'h0030; i++) begin
            checkOutput("final_mem", {16'h0, mem[i]}, {16'h0, ref_mem[i]});
        end
        checkOutput("final_mem_top", {16'h0, mem[32767]}, {16'h0, ref_mem[32767]});

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/mem_master.md
MEM_MASTER -- requirements
Module: mem_master

Interface
REQ-001 SHALL have the following ports, one per line: name, direction, width, meaning.
- clock  in  1  sole clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1=store, 0=load.
- req_byte  in  1  1=byte access, 0=16-bit word access.
- req_addr  in  16  byte address.
- req_wdata  in  16  store data; byte store uses [7:0].
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  16  load data; byte loads zero-extended.
- rsp_err  out  1  request rejected, qualified by rsp_valid.
- addrm  out  16  memory address, always even.
- wmdata  out  16  memory write data.
- re  out  1  memory read strobe.
- we  out  1  memory write strobe; the write commits at the clock edge that ends the we cycle.
- mem_alu  out  1  memory read-path select; held at 0 so rmdata is the combinational word at addrm.
- rmdata  in  16  memory read data, {high byte, low byte} of the word at addrm.

Function
REQ-002 SHALL implement FSM states IDLE, ACCESS, RMW_RD, RMW_WR and RESP.
REQ-003 SHALL assert req_ready only in IDLE; a request is accepted on a clock edge where req_valid=1 and req_ready=1.
REQ-004 SHALL register addr, we, byte and wdata on accept and hold them until the FSM returns to IDLE.
REQ-005 SHALL drive addrm = {addr[15:1],1'b0} from the registered address in every state.
REQ-006 SHALL route an accepted request as follows.
- Misaligned word access (byte=0, addr[0]=1): go to RESP with rsp_err=1; re and we are never asserted.
- Byte store: go to RMW_RD.
- All other requests: go to ACCESS.
REQ-007 In ACCESS for a word load, SHALL assert re=1 and capture rmdata into rsp_rdata.
REQ-008 In ACCESS for a byte load, SHALL assert re=1 and capture {8'h00, addr[0] ? rmdata[15:8] : rmdata[7:0]} into rsp_rdata.
REQ-009 In ACCESS for a word store, SHALL assert we=1 with wmdata=wdata.
REQ-010 In RMW_RD, SHALL assert re=1 and capture rmdata into a merge register, then go to RMW_WR.
REQ-011 In RMW_WR, SHALL assert we=1 with wmdata = the merge word with byte addr[0] replaced by wdata[7:0], then go to RESP.
REQ-012 SHALL go from ACCESS to RESP, and from RESP to IDLE.
REQ-013 SHALL assert rsp_valid=1 for exactly the RESP cycle; rsp_rdata and rsp_err hold their values until the next RESP.
REQ-014 SHALL leave rsp_rdata unchanged on stores and rejected requests.
REQ-015 SHALL give these latencies, counted from the accepting edge to rsp_valid high: 2 cycles for loads and word stores, 3 cycles for byte stores, 1 cycle for errors.
REQ-016 SHALL assert we and re in no state other than those listed above; we and re are never high in the same cycle.
REQ-017 SHALL not accept a new request in RESP; back-to-back requests wait for IDLE.
REQ-018 SHALL apply no response backpressure; rsp_valid is not stalled.
REQ-019 SHALL treat address 16'hFFFE/16'hFFFF as normal; there is no wrap beyond the 64 KiB space.

Reset
REQ-020 On reset_n=0, SHALL immediately force the following, independent of clock:
- state=IDLE;
- rsp_valid=0, rsp_err=0, rsp_rdata=0;
- addrm=0, wmdata=0;
- re=0, we=0, mem_alu=0.
REQ-021 A reset asserted during ACCESS or RMW_WR SHALL drop we asynchronously so that no write commits at the following edge; the in-flight request is discarded with no response.
REQ-022 After reset_n deasserts, SHALL present req_ready=1 in the first cycle.

Configuration
REQ-023 Macro MEM_MASTER_RMW_EN defined: byte stores SHALL use the RMW_RD/RMW_WR sequence of REQ-010 and REQ-011.
REQ-024 Macro MEM_MASTER_RMW_EN undefined: RMW_RD, RMW_WR and the merge register SHALL be absent; byte stores go to RESP with rsp_err=1 and no memory access; all other behaviour is unchanged.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- Word store addr=16'h0010, wdata=16'hBEEF, then word load 16'h0010 -> we pulse with addrm=16'h0010; load returns rsp_rdata=16'hBEEF 2 cycles after accept.
- Byte load addr=16'h0011 over memory word 16'hBEEF -> rsp_rdata=16'h00BE, rsp_err=0.
- Byte store addr=16'h0011, wdata=16'h0042, with RMW enabled, then word load -> 16'h42EF; rsp_valid 3 cycles after accept.
- Word load addr=16'h0013 -> rsp_valid 1 cycle after accept, rsp_err=1, re and we never asserted, rsp_rdata unchanged.
- reset_n pulled low during the we cycle of a word store to 16'h0020 holding 16'h1111 -> memory still reads 16'h1111; outputs at reset values; no rsp_valid.
- Byte store with MEM_MASTER_RMW_EN undefined -> rsp_err=1 one cycle after accept; we never asserted.
